alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 For each requester n in {0,1} (0 = core pipeline, 1 = sensor/motor coprocessor) the block SHALL provide: reqn_valid input 1; reqn_ready_o output 1; reqn_a input 32; reqn_b input 32; reqn_op input 4 (ALU control code).
REQ-003 For each requester n the block SHALL provide: rspn_valid_o output 1; rspn_ready input 1; rspn_result_o output 32; rspn_zero_o output 1; rspn_err_o output 1 (illegal opcode).
REQ-004 Toward the shared ALU the block SHALL provide: alu_a_o output 32; alu_b_o output 32; alu_ctrl_o output 4; alu_result input 32; alu_zero input 1.
REQ-005 Legal opcodes SHALL be ADD 0000, SUB 1000, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101; all other codes are illegal.

Function
REQ-006 FSM SHALL have states IDLE, EXEC, RESP; exactly one operation is in flight at any time.
REQ-007 In IDLE, reqn_ready_o SHALL be combinationally high only for the granted requester when its reqn_valid is high; in EXEC/RESP both readies SHALL be 0.
REQ-008 Accept SHALL occur on a rising edge with reqn_valid & reqn_ready_o; a, b, op and requester index are latched; IDLE->EXEC.
REQ-009 In EXEC, alu_a_o/alu_b_o/alu_ctrl_o SHALL drive the latched values; alu_result/alu_zero are registered at the end of EXEC; EXEC->RESP unconditionally.
REQ-010 Outside EXEC, alu_a_o, alu_b_o, alu_ctrl_o SHALL be 0.
REQ-011 Illegal opcode: block SHALL still sequence EXEC, but return result 0, zero 1, err 1; alu_ctrl_o driven 0000 in EXEC.
REQ-012 In RESP, rspn_valid_o SHALL be 1 only for the latched requester, with result/zero/err stable until rspn_ready is sampled high; then RESP->IDLE.
REQ-013 Response latency SHALL be exactly 2 cycles from accept edge to rspn_valid_o high; minimum issue interval 3 cycles.
REQ-014 rspn_result_o/zero_o/err_o of the non-selected requester SHALL be 0.
REQ-015 Arbitration SHALL be per REQ-021; single requester valid is always granted.
REQ-016 Requester deasserting reqn_valid before accept SHALL be legal; no operation is issued for it.
REQ-017 A new request from the requester whose response is pending SHALL wait until the response completes and the FSM returns to IDLE.

Reset
REQ-018 When rst is high at a rising edge, FSM SHALL go to IDLE, in-flight operation SHALL be discarded with no response, round-robin pointer SHALL select requester 0 as next winner.
REQ-019 While rst is high and after reset: all ready, valid, result, zero, err and alu_* outputs SHALL be 0.

Configuration
REQ-020 Macro ALU_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-021 With ALU_ARB_ROUND_ROBIN_EN defined: on simultaneous valid, grant the requester not granted last; pointer updates on each accept. Without it: fixed priority, requester 0 always wins ties, no pointer state.

Verification
REQ-022 Req0 ADD a=5 b=7, rsp0_ready=1 -> rsp0_valid 2 cycles after accept, result 12, zero 0, err 0.
REQ-023 Req1 SUB a=9 b=9 with rsp1_ready held 0 for 4 cycles -> rsp1_valid held 4+ cycles, result 0, zero 1, FSM stays RESP until ready.
REQ-024 Both valid every cycle, 4 ops each -> with macro: grants 0,1,0,1,...; without: all req0 ops before any req1.
REQ-025 Req0 op=1111 a=3 b=4 -> result 0, zero 1, err 1, alu_ctrl_o 0000 in EXEC.
REQ-026 Req0 SLL a=1 b=0x25 accepted, rst pulsed in EXEC -> no rsp0_valid, all outputs 0; next request SLL a=1 b=0x25 -> result 0x20.

Source files
------------

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters
// (0 = core pipeline, 1 = sensor/motor coprocessor). Only one operation is
// in flight at a time. Each operation goes through IDLE -> EXEC -> RESP.
//
// Configuration macro: ALU_ARB_ROUND_ROBIN_EN
//   defined   : round-robin on simultaneous requests. A pointer remembers
//               which requester wins the next tie.
//   undefined : fixed priority. Requester 0 wins ties. There is no pointer.
//
// Ports
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   reqN_valid/ready_o       request handshake for requester N
//   reqN_a, reqN_b, reqN_op  operands and 4-bit ALU control code
//   rspN_valid_o/rspN_ready  response handshake for requester N
//   rspN_result_o/zero_o/err_o  response payload (err = illegal opcode)
//   alu_a_o/b_o/ctrl_o       operands and control sent to the shared ALU
//   alu_result, alu_zero     result returned by the shared ALU
//   state_o                  debug view of the FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Handshake rules (both directions):
//   A transfer happens on a rising edge where valid and ready are both high.
//   On the request side, ready_o is combinational from valid, so a requester
//   may drop valid before it is accepted. On the response side, valid_o and
//   its payload stay stable until the transfer happens.
// ---------------------------------------------------------------------------
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready_o,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready_o,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_op,
    output logic        rsp0_valid_o,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result_o,
    output logic        rsp0_zero_o,
    output logic        rsp0_err_o,
    output logic        rsp1_valid_o,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result_o,
    output logic        rsp1_zero_o,
    output logic        rsp1_err_o,
    output logic [31:0] alu_a_o,
    output logic [31:0] alu_b_o,
    output logic [3:0]  alu_ctrl_o,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;
    localparam logic [3:0] OP_AND = 4'b0111;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SLL = 4'b0001;
    localparam logic [3:0] OP_SRL = 4'b0101;

    function automatic logic op_legal(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    endfunction

    state_t      state_q,  state_d;
    logic [31:0] a_q,      a_d;
    logic [31:0] b_q,      b_d;
    logic [3:0]  op_q,     op_d;
    logic        sel_q,    sel_d;
    logic [31:0] result_q, result_d;
    logic        zero_q,   zero_d;
    logic        err_q,    err_d;

    logic gnt0, gnt1;
    logic acc0, acc1;
    logic legal_q;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // 1 means requester 1 wins the next tie.
    logic rr_ptr_q, rr_ptr_d;
`endif

    assign legal_q = op_legal(op_q);

    // Grant selection. This logic only looks at the valids. The FSM state
    // and reset gate the grant further down, where the readies are formed.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            gnt0 = ~rr_ptr_q;
            gnt1 = rr_ptr_q;
        end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
        end
`else
        gnt0 = req0_valid;
        gnt1 = req1_valid & ~req0_valid;
`endif
    end

    // Readies are held low during reset, so nothing is accepted while rst is high.
    assign req0_ready_o = ~rst & (state_q == IDLE) & gnt0;
    assign req1_ready_o = ~rst & (state_q == IDLE) & gnt1;
    assign acc0         = req0_ready_o;
    assign acc1         = req1_ready_o;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        sel_d    = sel_q;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (acc0 || acc1) begin
                    a_d     = acc1 ? req1_a  : req0_a;
                    b_d     = acc1 ? req1_b  : req0_b;
                    op_d    = acc1 ? req1_op : req0_op;
                    sel_d   = acc1;
                    state_d = EXEC;
`ifdef ALU_ARB_ROUND_ROBIN_EN
                    // The requester that was just served loses the next tie.
                    rr_ptr_d = acc0;
`endif
                end
            end
            EXEC: begin
                // An illegal opcode still uses its EXEC slot. The ALU output
                // is ignored and the error response is returned instead.
                if (legal_q) begin
                    result_d = alu_result;
                    zero_d   = alu_zero;
                    err_d    = 1'b0;
                end else begin
                    result_d = 32'd0;
                    zero_d   = 1'b1;
                    err_d    = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                if (sel_q ? rsp1_ready : rsp0_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            op_q     <= 4'd0;
            sel_q    <= 1'b0;
            result_q <= 32'd0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            sel_q    <= sel_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // The ALU bus is driven only during EXEC, and is zero otherwise.
    // Reset also forces it to zero.
    always_comb begin
        alu_a_o    = 32'd0;
        alu_b_o    = 32'd0;
        alu_ctrl_o = 4'd0;
        if (!rst && state_q == EXEC) begin
            alu_a_o    = a_q;
            alu_b_o    = b_q;
            alu_ctrl_o = legal_q ? op_q : 4'd0;
        end
    end

    // The payload is shown only on the selected channel. The other channel
    // stays at zero.
    always_comb begin
        rsp0_valid_o  = 1'b0;
        rsp1_valid_o  = 1'b0;
        rsp0_result_o = 32'd0;
        rsp0_zero_o   = 1'b0;
        rsp0_err_o    = 1'b0;
        rsp1_result_o = 32'd0;
        rsp1_zero_o   = 1'b0;
        rsp1_err_o    = 1'b0;
        if (!rst && state_q == RESP) begin
            if (sel_q) begin
                rsp1_valid_o  = 1'b1;
                rsp1_result_o = result_q;
                rsp1_zero_o   = zero_q;
                rsp1_err_o    = err_q;
            end else begin
                rsp0_valid_o  = 1'b1;
                rsp0_result_o = result_q;
                rsp0_zero_o   = zero_q;
                rsp0_err_o    = err_q;
            end
        end
    end

    assign state_o = state_q;

endmodule
